// File: rtl/imem_loader_if.sv
// ============================================================================
// Module : imem_loader_if
// Desc   : Command handshake and instruction-memory write bus for imem_loader.
//          With IMEM_VERIFY_EN defined, also carries the read-back channel.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [4:0]        cmd_rs;
  logic [4:0]        cmd_rt;
  logic [4:0]        cmd_rd;
  logic [15:0]       cmd_imm;
  logic [25:0]       cmd_target;

  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

`ifdef IMEM_VERIFY_EN
  logic              imem_re;
  logic [31:0]       imem_rdata;

  // Command source / memory side
  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, imem_rdata,
    input  cmd_ready, imem_we, imem_addr, imem_wdata, imem_re
  );

  // Loader side
  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, imem_rdata,
    output cmd_ready, imem_we, imem_addr, imem_wdata, imem_re
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
`endif

endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Desc   : Encodes symbolic add/addi/lw/sw/bgtz/j commands into MIPS words and
//          writes them sequentially into instruction memory. Optional macro
//          IMEM_VERIFY_EN adds a read-back check after every write.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  imem_loader_if.slave      bus,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic              err_op
`ifdef IMEM_VERIFY_EN
  ,
  output logic              verify_err
`endif
);

  localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_addr_max = '1;

`ifdef IMEM_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_FULL  = 3'd3,
    S_DONE  = 3'd4,
    S_VRD   = 3'd5,
    S_VCHK  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_FULL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  state_t            w_after;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_err_op;
  logic              r_fin_pend;

  logic [31:0]       w_enc;
  logic              w_legal;
  logic              w_hs;
  logic              w_ready;
  logic              w_we;
  logic              w_advance;
  logic              w_fin_track;
  logic              w_start_ok;
  logic [ADDR_W:0]   w_count_inc;

`ifdef IMEM_VERIFY_EN
  logic              r_verify_err;
  logic              w_re;
  logic              w_vfail;
`endif

  // Instruction encoder; unused command fields never reach the word.
  always_comb begin
    w_enc   = 32'h0000_0000;
    w_legal = 1'b1;
    case (bus.cmd_op)
      3'd0:    w_enc = {6'h00, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'h00, 6'h20};
      3'd1:    w_enc = {6'h08, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
      3'd2:    w_enc = {6'h23, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
      3'd3:    w_enc = {6'h2B, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
      3'd4:    w_enc = {6'h07, bus.cmd_rs, 5'h00, bus.cmd_imm};
      3'd5:    w_enc = {6'h02, bus.cmd_target};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_hs        = bus.cmd_valid & w_ready;
  assign w_count_inc = r_count + 1'b1;
  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // Where a completed write goes: a pending or concurrent finish wins over FULL.
  always_comb begin
    if (r_fin_pend || finish) begin
      w_after = S_DONE;
    end else if (w_count_inc == c_depth) begin
      w_after = S_FULL;
    end else begin
      w_after = S_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_we        = 1'b0;
    w_advance   = 1'b0;
    w_fin_track = 1'b0;
`ifdef IMEM_VERIFY_EN
    w_re        = 1'b0;
    w_vfail     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_hs && w_legal) begin
          w_next      = S_WRITE;
          w_fin_track = 1'b1;
        end else if (finish) begin
          w_next = S_DONE;
        end
      end
      S_WRITE: begin
        w_we        = 1'b1;
        w_fin_track = 1'b1;
`ifdef IMEM_VERIFY_EN
        w_next      = S_VRD;
`else
        w_advance   = 1'b1;
        w_next      = w_after;
`endif
      end
`ifdef IMEM_VERIFY_EN
      S_VRD: begin
        w_re        = 1'b1;
        w_fin_track = 1'b1;
        w_next      = S_VCHK;
      end
      S_VCHK: begin
        w_fin_track = 1'b1;
        if (bus.imem_rdata == r_wdata) begin
          w_advance = 1'b1;
          w_next    = w_after;
        end else begin
          w_vfail = 1'b1;
          w_next  = S_DONE;
        end
      end
`endif
      S_FULL: begin
        if (finish) w_next = S_DONE;
      end
      S_DONE: begin
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= c_base;
      r_count    <= '0;
      r_wdata    <= 32'h0000_0000;
      r_err_op   <= 1'b0;
      r_fin_pend <= 1'b0;
`ifdef IMEM_VERIFY_EN
      r_verify_err <= 1'b0;
`endif
    end else begin
      if (w_start_ok) begin
        r_addr     <= c_base;
        r_count    <= '0;
        r_err_op   <= 1'b0;
        r_fin_pend <= 1'b0;
`ifdef IMEM_VERIFY_EN
        r_verify_err <= 1'b0;
`endif
      end
      if (w_hs) begin
        if (w_legal) begin
          r_wdata <= w_enc;
        end else begin
          r_err_op <= 1'b1;
        end
      end
      if (finish && w_fin_track) r_fin_pend <= 1'b1;
      if (w_next == S_DONE) r_fin_pend <= 1'b0;
      if (w_advance) begin
        // Saturate rather than wrap when the session ends on the top word.
        if (r_addr != c_addr_max) r_addr <= r_addr + 1'b1;
        r_count <= w_count_inc;
      end
`ifdef IMEM_VERIFY_EN
      if (w_vfail) r_verify_err <= 1'b1;
`endif
    end
  end

  assign bus.cmd_ready  = w_ready;
  assign bus.imem_we    = w_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;

  assign count  = r_count;
  assign busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign full   = (r_state == S_FULL);
  assign done   = (r_state == S_DONE);
  assign err_op = r_err_op;

`ifdef IMEM_VERIFY_EN
  assign bus.imem_re = w_re;
  assign verify_err  = r_verify_err;
`endif

endmodule

`default_nettype wire
